// File: rtl/config_arbiter_pkg.sv
// Shared constants for the configuration-register arbiter: default geometry,
// FSM state encoding and the round-robin index helper.
package config_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_DATA_W  = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t RESP   = 2'd2;

  // Requester index `offset` positions after `base`, wrapping at `n`.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/cfg_reg_bank.sv
// Register file behind the arbiter: single write port, combinational read,
// every entry cleared by reset.
module cfg_reg_bank
  import config_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data = regs[rd_addr];

endmodule

// File: rtl/config_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters access to a shared register
// bank; each transaction takes IDLE -> ACCESS -> RESP with fixed latency.
module config_arbiter
  import config_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic [ID_W-1:0]   next_winner;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] rd_data;
  logic              bank_wr_en;

  // First valid requester strictly after last_grant, wrapping around.
  always_comb begin
    found       = 1'b0;
    cand        = '0;
    next_winner = last_grant;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'(rr_index(int'(last_grant), i, NUM_REQ));
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        next_winner = cand;
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == next_winner) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      rsp_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id  <= next_winner;
            cap_we    <= sel_we;
            cap_addr  <= sel_addr;
            cap_wdata <= sel_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // Writes echo the stored value so the response is uniform.
          rsp_rdata <= cap_we ? cap_wdata : rd_data;
          state     <= RESP;
        end
        RESP: begin
          last_grant <= grant_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bank_wr_en = (state == ACCESS) && cap_we;

  cfg_reg_bank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) reg_bank_inst (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bank_wr_en),
    .wr_addr (cap_addr),
    .wr_data (cap_wdata),
    .rd_addr (cap_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    req_ready = '0;
    if (state == RESP) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_config_arbiter.sv
// Scoreboard bench for config_arbiter: expected responses are queued as
// requests are driven and matched against each req_ready pulse.
module tb_config_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;

  typedef struct {
    int              id;
    logic [DATA_W-1:0] rdata;
    int              due;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] model_mem [8];
  int                cyc;
  int                checks;
  int                errors;

  config_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) config_arbiter_inst (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input int id, input logic we, input int addr,
                                   input logic [DATA_W-1:0] wdata, input int due);
    exp_t e;
    e.id    = id;
    e.rdata = we ? wdata : model_mem[addr];
    e.due   = due;
    if (we) model_mem[addr] = wdata;
    sb.push_back(e);
  endfunction

  task automatic set_req(input int id, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata);
    req_we[id]                     = we;
    req_addr[id*ADDR_W +: ADDR_W]  = addr;
    req_wdata[id*DATA_W +: DATA_W] = wdata;
  endtask

  // Drops each requester's valid on the edge after its ready pulse.
  task automatic wait_and_release(input logic [NUM_REQ-1:0] mask);
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] done;
    int guard;
    pending = mask;
    guard   = 0;
    while (pending != 0 && guard < 40) begin
      @(negedge clk);
      done = req_ready & pending;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~done;
      pending   = pending & ~done;
      guard++;
    end
    checkOutput("ready_pending", 32'(pending), 32'h0);
  endtask

  task automatic applyStimulus(input int id, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata);
    @(posedge clk);
    #1;
    set_req(id, we, addr, wdata);
    req_valid[id] = 1'b1;
    push_exp(id, we, int'(addr), wdata, cyc + 2);
    wait_and_release(NUM_REQ'(1 << id));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model_mem[i] = '0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && req_ready != 0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_ready", 32'(req_ready), 32'h0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("ready_onehot", 32'(req_ready), 32'(1 << mon_e.id));
          checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
          checkOutput("grant_id", 32'(grant_id), 32'(mon_e.id));
          checkOutput("busy_in_resp", 32'(busy), 32'h1);
          if (mon_e.due >= 0) checkOutput("latency", 32'(cyc), 32'(mon_e.due));
        end
      end
    end
  end

  initial begin
    int k;
    int n;
    int guard;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'h0);
    checkOutput("rst_rdata", 32'(rsp_rdata), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 1'b1, 3'd3, 8'hA5);
    @(negedge clk);
    checkOutput("rdata_hold", 32'(rsp_rdata), 32'hA5);
    checkOutput("idle_busy", 32'(busy), 32'h0);
    applyStimulus(2, 1'b0, 3'd3, 8'h00);
    applyStimulus(2, 1'b0, 3'd4, 8'h00);

    // Requester 1 withdraws and scrambles its fields while in ACCESS.
    @(posedge clk);
    #1;
    set_req(1, 1'b1, 3'd5, 8'h3C);
    req_valid[1] = 1'b1;
    push_exp(1, 1'b1, 5, 8'h3C, cyc + 2);
    @(posedge clk);
    #1;
    checkOutput("busy_access", 32'(busy), 32'h1);
    req_valid[1] = 1'b0;
    set_req(1, 1'b1, 3'd0, 8'h99);
    wait_and_release(4'b0010);
    applyStimulus(3, 1'b0, 3'd5, 8'h00);
    applyStimulus(3, 1'b0, 3'd0, 8'h00);

    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, ADDR_W'(i), DATA_W'(8'h10 + i));
    req_valid = 4'b1111;
    k = cyc;
    for (int t = 0; t < 12; t++) push_exp(t % 4, 1'b1, t % 4, DATA_W'(8'h10 + (t % 4)), k + 2 + 3 * t);
    n = 0;
    guard = 0;
    while (n < 12 && guard < 100) begin
      @(negedge clk);
      if (req_ready != 0) n++;
      guard++;
    end
    checkOutput("rr_count", 32'(n), 32'd12);
    @(posedge clk);
    #1;
    req_valid = '0;
    applyStimulus(0, 1'b0, 3'd2, 8'h00);

    // Reset lands while a write of 0xFF to addr 7 is in ACCESS.
    @(posedge clk);
    #1;
    set_req(0, 1'b1, 3'd7, 8'hFF);
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_busy_before", 32'(busy), 32'h1);
    rst_n     = 1'b0;
    req_valid = '0;
    clear_model();
    #1;
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_ready", 32'(req_ready), 32'h0);
    checkOutput("abort_rdata", 32'(rsp_rdata), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    @(posedge clk);
    #1;
    set_req(0, 1'b0, 3'd7, 8'h00);
    set_req(3, 1'b1, 3'd2, 8'h77);
    req_valid = 4'b1001;
    push_exp(0, 1'b0, 7, 8'h00, cyc + 2);
    push_exp(3, 1'b1, 2, 8'h77, cyc + 5);
    wait_and_release(4'b1001);
    applyStimulus(1, 1'b0, 3'd2, 8'h00);
    applyStimulus(2, 1'b0, 3'd3, 8'h00);

    repeat (4) @(posedge clk);
    checkOutput("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
